// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

    // Widest requester vector the helpers handle; callers zero-extend into it.
    localparam int ARB_MAX_WIDTH = 64;

    typedef logic [ARB_MAX_WIDTH-1:0] arb_vec_t;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_t;

    // Isolate the lowest set bit of x (zero stays zero).
    function automatic arb_vec_t lsb_onehot(input arb_vec_t x);
        return x & (~x + arb_vec_t'(1));
    endfunction

    // Binary encode of a one-hot vector; zero maps to zero.
    function automatic int unsigned onehot2idx(input arb_vec_t x);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_WIDTH; i++) begin
            if (x[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin pick: lowest request strictly above the last
// owner, otherwise wrap around to the lowest request overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [WIDTH-1:0] pick_onehot,
    output logic [IW-1:0]    pick_idx
);

    arb_vec_t req_ext;
    arb_vec_t upto_last;
    arb_vec_t hi;
    arb_vec_t pick_ext;

    // Mask off requests at or below the last owner, then take the lowest survivor.
    always_comb begin
        req_ext   = arb_vec_t'(req);
        upto_last = (arb_vec_t'(2) << last) - arb_vec_t'(1);
        hi        = req_ext & ~upto_last;
        if (hi != '0) begin
            pick_ext = lsb_onehot(hi);
        end else begin
            pick_ext = lsb_onehot(req_ext);
        end
        pick_onehot = pick_ext[WIDTH-1:0];
        pick_idx    = IW'(onehot2idx(pick_ext));
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with per-ownership hold limit and back-to-back handover.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(WIDTH),
    parameter int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             gnt_val_o,
    output logic [HW-1:0]    hold_cnt_o
);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [WIDTH-1:0] gnt_q,   gnt_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic             val_q,   val_d;
    logic [HW-1:0]    hold_q,  hold_d;

    logic [WIDTH-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             release_now;

    rr_pick #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_pick (
        .req         (req_i),
        .last        (last_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // Register state, pointer and all outputs; reset returns to an empty idle arbiter.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(WIDTH - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            hold_q  <= hold_d;
        end
    end

    // Decide grant load, hold, handover or return to idle.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        val_d       = val_q;
        hold_d      = hold_q;
        release_now = !req_i[idx_q] || (hold_q == HW'(MAX_HOLD - 1));

        unique case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                    val_d   = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_d = hold_q + HW'(1);
                end else if (pick_onehot != '0) begin
                    gnt_d  = pick_onehot;
                    idx_d  = pick_idx;
                    last_d = pick_idx;
                    val_d  = 1'b1;
                    hold_d = '0;
                end else begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    val_d   = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o      = gnt_q;
    assign gnt_idx_o  = idx_q;
    assign gnt_val_o  = val_q;
    assign hold_cnt_o = hold_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter with WIDTH=4, MAX_HOLD=4.
module tb_rr_grant_arbiter;

    localparam int W  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       srst_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_val_o;
    logic [2:0] hold_cnt_o;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: current owner (-1 when idle), its hold count, last owner.
    int owner  = -1;
    int holdM  = 0;
    int lastM  = W - 1;

    rr_grant_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .gnt_idx_o  (gnt_idx_o),
        .gnt_val_o  (gnt_val_o),
        .hold_cnt_o (hold_cnt_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Circular scan starting just after the last owner; -1 if nobody requests.
    function automatic int pickNext(input logic [3:0] req, input int last);
        for (int k = 1; k <= W; k++) begin
            int i;
            i = (last + k) % W;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge.
    function automatic void modelStep(input logic [3:0] req, input logic rst);
        int p;
        if (rst) begin
            owner = -1;
            holdM = 0;
            lastM = W - 1;
        end else if (owner < 0) begin
            p = pickNext(req, lastM);
            if (p >= 0) begin
                owner = p;
                lastM = p;
                holdM = 0;
            end
        end else if (req[owner] && holdM < MH - 1) begin
            holdM = holdM + 1;
        end else begin
            p = pickNext(req, lastM);
            if (p >= 0) begin
                owner = p;
                lastM = p;
                holdM = 0;
            end else begin
                owner = -1;
                holdM = 0;
            end
        end
    endfunction

    task automatic checkOutput();
        logic [3:0] expGnt;
        logic [1:0] expIdx;
        logic       expVal;
        logic [2:0] expHold;
        expGnt  = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        expIdx  = (owner < 0) ? 2'd0 : 2'(owner);
        expVal  = (owner >= 0);
        expHold = 3'(holdM);

        vecCount++;
        assert (gnt_o === expGnt) else begin
            missCount++;
            $display("[TB] FAIL gnt_o: observed %b expected %b", gnt_o, expGnt);
            $error("[TB] gnt_o miscompare");
        end
        vecCount++;
        assert (gnt_idx_o === expIdx) else begin
            missCount++;
            $display("[TB] FAIL gnt_idx_o: observed %0d expected %0d", gnt_idx_o, expIdx);
            $error("[TB] gnt_idx_o miscompare");
        end
        vecCount++;
        assert (gnt_val_o === expVal) else begin
            missCount++;
            $display("[TB] FAIL gnt_val_o: observed %b expected %b", gnt_val_o, expVal);
            $error("[TB] gnt_val_o miscompare");
        end
        vecCount++;
        assert (hold_cnt_o === expHold) else begin
            missCount++;
            $display("[TB] FAIL hold_cnt_o: observed %0d expected %0d", hold_cnt_o, expHold);
            $error("[TB] hold_cnt_o miscompare");
        end
    endtask

    // Directed check of the grant vector against a hand-derived constant.
    task automatic checkGrant(input string tag, input logic [3:0] expGnt);
        vecCount++;
        assert (gnt_o === expGnt) else begin
            missCount++;
            $display("[TB] FAIL %s: observed %b expected %b", tag, gnt_o, expGnt);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check after it.
    task automatic applyStimulus(input logic [3:0] req, input logic rst);
        @(negedge clk);
        req_i  = req;
        srst_i = rst;
        @(posedge clk);
        modelStep(req, rst);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] r;
        logic       rs;
        req_i  = 4'b0000;
        srst_i = 1'b1;

        // Reset state and idle
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b0);
        checkGrant("idle_after_reset", 4'b0000);

        // First grant and voluntary release with back-to-back handover
        applyStimulus(4'b1010, 1'b0);
        checkGrant("first_grant", 4'b0010);
        applyStimulus(4'b1000, 1'b0);
        checkGrant("handover_to_3", 4'b1000);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Forced release and wrap
        repeat (20) applyStimulus(4'b1111, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Sole requester
        repeat (12) applyStimulus(4'b0100, 1'b0);
        checkGrant("sole_requester", 4'b0100);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Non-owner arrival during an active grant
        repeat (2) applyStimulus(4'b0100, 1'b0);
        repeat (2) applyStimulus(4'b0101, 1'b0);
        checkGrant("non_owner_held_off", 4'b0100);
        applyStimulus(4'b0101, 1'b0);
        checkGrant("non_owner_wrap", 4'b0001);
        repeat (3) applyStimulus(4'b0101, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Reset mid-grant: last owner 0, so 1111 walks 1,2,3
        repeat (9) applyStimulus(4'b1111, 1'b0);
        checkGrant("owner3_before_reset", 4'b1000);
        applyStimulus(4'b1111, 1'b1);
        checkGrant("reset_mid_grant", 4'b0000);
        applyStimulus(4'b1111, 1'b0);
        checkGrant("first_after_reset", 4'b0001);

        // Randomized traffic with owners usually keeping their request
        for (int n = 0; n < 400; n++) begin
            r = 4'($urandom_range(0, 15));
            if (owner >= 0 && $urandom_range(0, 3) != 0) begin
                r[owner] = 1'b1;
            end
            rs = ($urandom_range(0, 63) == 0);
            applyStimulus(r, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource between `WIDTH` requesters. It uses lowest-set-bit priority encoding over a rotating mask, holds each grant until the owner drops its request or a hold limit expires, and re-arbitrates back-to-back with no idle cycle. It sits in front of the shared encoder/datapath and drives that resource's one-hot select and valid.

## Interface
- `WIDTH`, 16: number of requesters; must be ≥ 2.
- `MAX_HOLD`, 8: maximum consecutive grant cycles per ownership; must be ≥ 1.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `srst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  WIDTH  per-requester request level; the owner holds it high while it uses the resource.
- `gnt_o`  out  WIDTH  one-hot grant; all zero when idle.
- `gnt_idx_o`  out  $clog2(WIDTH)  binary index of the current owner; 0 when idle.
- `gnt_val_o`  out  1  high while any grant is active.
- `hold_cnt_o`  out  $clog2(MAX_HOLD+1)  cycles the current owner has held the grant, minus 1; 0 when idle.

## Operation
- **FSM states:** IDLE, GRANT.
- **Last-owner pointer:** `last_q` holds the index of the most recent owner. Reset value is `WIDTH-1`, so the first search starts at bit 0.
- **Pick function**, computed combinationally from `req_i` and `last_q`:
  - `hi = req_i & ~((2 << last_q) - 1)`, i.e. requests strictly above `last_q`.
  - If `hi != 0`, pick `hi & (~hi + 1)`; otherwise pick `req_i & (~req_i + 1)`.
  - Result is one-hot or zero. The index is the binary encode of that one-hot.
- **IDLE:**
  - If `req_i == 0`, stay in IDLE.
  - Otherwise load `gnt_o` with the pick, set `gnt_idx_o` and `last_q` to its index, set `hold_cnt_o` to 0, and go to GRANT.
- **GRANT, each cycle:**
  - Release when `req_i[gnt_idx_o] == 0` (voluntary) or `hold_cnt_o == MAX_HOLD-1` (forced).
  - No release: increment `hold_cnt_o`.
  - Release with the pick nonzero: load the new grant directly, reset `hold_cnt_o` to 0, and stay in GRANT.
  - Release with the pick zero: clear the grant outputs and go to IDLE.
- **Forced release:** the owner is re-granted only when no other requester is pending; the wrap search then returns it. Its hold count restarts at 0.
- **Requests from non-owners** never disturb an active grant before release.
- **Invariants:**
  - `gnt_o` is always zero or one-hot.
  - `gnt_val_o == |gnt_o`.
  - `gnt_o[gnt_idx_o] == gnt_val_o`.
- **Reset:**
  - Asserted on any edge, it forces IDLE, `gnt_o = 0`, `gnt_idx_o = 0`, `gnt_val_o = 0`, `hold_cnt_o = 0`, `last_q = WIDTH-1`.
  - This applies mid-grant as well; no request is remembered across reset.

## Timing
- **Grant latency:** 1 cycle. A request sampled high at edge n from IDLE gives a grant visible after edge n.
- **Release latency:** 1 cycle. The owner's `req_i` low sampled at edge n gives the grant moved or cleared after edge n. The requester must tolerate one extra granted cycle after it drops `req_i`.
- **Back-to-back handover:** `gnt_val_o` stays high with no gap; `gnt_o` switches one-hot bit in a single edge.
- **Maximum ownership:** exactly `MAX_HOLD` consecutive cycles. With `MAX_HOLD=1`, every cycle re-arbitrates.
- **Fairness:** any requester that holds `req_i` high is granted within `(WIDTH-1)*MAX_HOLD + 1` cycles.
- **Input timing:** all outputs are registered; there is no combinational path from `req_i` to outputs.

## Structure
- **Package `arb_pkg`:**
  - `typedef enum logic [0:0] {IDLE, GRANT} arb_state_t`.
  - Function `lsb_onehot(x)` returning `x & (~x + 1)`.
  - Function `onehot2idx` (one-hot to binary encode).
- **Sub-module `rr_pick`:** combinational, parameter `WIDTH`, inputs `req` and `last`, outputs `pick_onehot` and `pick_idx`. It is instantiated once.
- **Top module:** holds the FSM, `last_q`, the hold counter and the output registers.

## Test plan
All scenarios use WIDTH=4 and MAX_HOLD=4 after reset.
- **Reset state:** reset, then `req_i=0000` → `gnt_o=0000`, `gnt_val_o=0`, `gnt_idx_o=0` on every cycle.
- **First grant and voluntary release:** `req_i=1010` held → grant `0010` (idx 1) after 1 edge. Drop bit 1 so `req_i=1000` → next edge `gnt_o=1000` (idx 3) with `gnt_val_o` staying high.
- **Forced release and wrap:** `req_i=1111` held → grants 0001, 0010, 0100, 1000, 0001 in turn, each exactly 4 cycles; `hold_cnt_o` counts 0,1,2,3 during each.
- **Sole requester:** `req_i=0100` held for 12 cycles → `gnt_o=0100` continuously; `hold_cnt_o` wraps 0..3 three times.
- **Non-owner arrival:** owner idx 2 at hold_cnt 1, then `req_i` goes to `0101` → grant stays `0100` until the forced release, then moves to `0001` (wrap), not back to idx 2.
- **Reset mid-grant:** `srst_i` pulsed while `gnt_o=1000` and `req_i=1111` → outputs zero after that edge. The first grant after reset release is `0001`.
